phi_add_datapath: RTL and testbench



---
 rtl/phi_add_datapath_pkg.sv | 13 +
 rtl/phi_add_datapath_if.sv | 49 ++++
 rtl/br_dummy.sv | 3 +
 rtl/phi_add_datapath_phi_select.sv | 52 +++++
 rtl/phi_add_datapath.sv | 69 ++++++
 tb/tb_phi_add_datapath.sv | 163 ++++++++++++++++
 6 files changed

// File: rtl/phi_add_datapath_pkg.sv
// Shared definitions for the phi/add datapath slice: default sizes,
// the basic-block ID type and the value phi_out takes when no pair matches.
package phi_add_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_NB_PAIR = 2;
  localparam int DEFAULT_ID_W    = 32;

  typedef logic [DEFAULT_ID_W-1:0] block_id_t;

  localparam int NO_MATCH_VALUE = 0;

endpackage

// File: rtl/phi_add_datapath_if.sv
// Signal bundle for phi_add_datapath.
// Optional feature macro: PHI_MULTI_MATCH_CHECK_EN adds phi_multi.
//
// Handshake: there is none. All inputs are level signals; the phi and adder
// outputs follow them combinationally, and the only sampling point is the
// clock edge on which capture=1 loads sum into sum_q (visible one cycle later).
interface phi_add_datapath_if
  import phi_add_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NB_PAIR = DEFAULT_NB_PAIR,
  parameter int ID_W    = DEFAULT_ID_W
) ();

  logic [NB_PAIR*WIDTH-1:0] phi_in;
  logic [NB_PAIR*ID_W-1:0]  phi_s;
  logic [ID_W-1:0]          last_block;
  logic [WIDTH-1:0]         phi_out;
  logic                     phi_hit;
  logic [WIDTH-1:0]         add_in1;
  logic [WIDTH-1:0]         sum;
  logic                     carry;
  logic                     capture;
  logic [WIDTH-1:0]         sum_q;
`ifdef PHI_MULTI_MATCH_CHECK_EN
  logic                     phi_multi;

  modport slave (
    input  phi_in, phi_s, last_block, add_in1, capture,
    output phi_out, phi_hit, sum, carry, sum_q, phi_multi
  );

  modport master (
    output phi_in, phi_s, last_block, add_in1, capture,
    input  phi_out, phi_hit, sum, carry, sum_q, phi_multi
  );
`else
  modport slave (
    input  phi_in, phi_s, last_block, add_in1, capture,
    output phi_out, phi_hit, sum, carry, sum_q
  );

  modport master (
    output phi_in, phi_s, last_block, add_in1, capture,
    input  phi_out, phi_hit, sum, carry, sum_q
  );
`endif

endinterface

// File: rtl/br_dummy.sv
// Portless stand-in for the branch unit of generated controllers; it has no logic.
module br_dummy;
endmodule

// File: rtl/phi_add_datapath_phi_select.sv
// Phi selector: picks the value of the lowest-indexed pair whose block ID
// equals last_block; zero when nothing matches.
// Optional feature macro: PHI_MULTI_MATCH_CHECK_EN adds the multi output.
module phi_select
  import phi_add_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NB_PAIR = DEFAULT_NB_PAIR,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic [NB_PAIR*WIDTH-1:0] values,
  input  logic [NB_PAIR*ID_W-1:0]  ids,
  input  logic [ID_W-1:0]          last_block,
  output logic [WIDTH-1:0]         value,
`ifdef PHI_MULTI_MATCH_CHECK_EN
  output logic                     multi,
`endif
  output logic                     hit
);

  logic [NB_PAIR-1:0] match;

  for (genvar k = 0; k < NB_PAIR; k++) begin : g_match
    assign match[k] = (ids[k*ID_W +: ID_W] == last_block);
  end

  assign hit = |match;

  // Priority mux: walk from the top index down so the lowest match is written last.
  always_comb begin
    value = WIDTH'(NO_MATCH_VALUE);
    for (int k = NB_PAIR - 1; k >= 0; k--) begin
      if (match[k]) begin
        value = values[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef PHI_MULTI_MATCH_CHECK_EN
  // Two-or-more detector: a match after an earlier match flags multi.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < NB_PAIR; k++) begin
      multi = multi | (seen & match[k]);
      seen  = seen | match[k];
    end
  end
`endif

endmodule

// File: rtl/phi_add_datapath.sv
// Phi selector feeding a wrap-around adder whose sum can be captured into a
// holding register (the loop-carried value of a generated loop).
// Optional feature macro: PHI_MULTI_MATCH_CHECK_EN exposes phi_multi and adds
// a simulation check against ambiguous phi matches.
module phi_add_datapath
  import phi_add_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NB_PAIR = DEFAULT_NB_PAIR,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input logic clk,
  input logic rst,
  phi_add_datapath_if.slave bus
);

  logic [WIDTH-1:0] phi_value;
  logic             phi_hit_w;
  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] sum_q_r;
`ifdef PHI_MULTI_MATCH_CHECK_EN
  logic             multi_w;
`endif

  phi_select #(
    .WIDTH   (WIDTH),
    .NB_PAIR (NB_PAIR),
    .ID_W    (ID_W)
  ) u_phi_select (
    .values     (bus.phi_in),
    .ids        (bus.phi_s),
    .last_block (bus.last_block),
    .value      (phi_value),
`ifdef PHI_MULTI_MATCH_CHECK_EN
    .multi      (multi_w),
`endif
    .hit        (phi_hit_w)
  );

  br_dummy u_br_dummy ();

  // One extra bit keeps the carry out of the wrap-around addition.
  assign full_sum = {1'b0, phi_value} + {1'b0, bus.add_in1};

  assign bus.phi_out = phi_value;
  assign bus.phi_hit = phi_hit_w;
  assign bus.sum     = full_sum[WIDTH-1:0];
  assign bus.carry   = full_sum[WIDTH];
  assign bus.sum_q   = sum_q_r;
`ifdef PHI_MULTI_MATCH_CHECK_EN
  assign bus.phi_multi = multi_w;
`endif

  // Loop-carried register: reset wins over capture, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q_r <= '0;
    end else if (bus.capture) begin
      sum_q_r <= full_sum[WIDTH-1:0];
    end
  end

`ifdef PHI_MULTI_MATCH_CHECK_EN
  // Ambiguous phi selection usually means a mis-generated controller.
  multi_match_chk : assert property (@(posedge clk) disable iff (rst) !multi_w)
    else $error("phi_add_datapath: several phi pairs match last_block %0d", bus.last_block);
`endif

endmodule

// File: tb/tb_phi_add_datapath.sv
// Self-checking bench for phi_add_datapath (WIDTH=20, NB_PAIR=2, ID_W=32).
module tb_phi_add_datapath;
  import phi_add_pkg::*;

  localparam int W  = 20;
  localparam int NB = 2;
  localparam int IW = 32;
  localparam int COUNT_N = 1500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phi_add_datapath_if #(.WIDTH(W), .NB_PAIR(NB), .ID_W(IW)) dif ();

  phi_add_datapath #(.WIDTH(W), .NB_PAIR(NB), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_sum_q = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: lowest matching pair, plain arithmetic for the sum.
  logic [W-1:0] m_val[NB];
  block_id_t    m_id[NB];
  logic [W-1:0] r_out;
  logic         r_hit;
  logic         r_multi;
  logic [W-1:0] r_sum;
  logic         r_carry;

  task automatic ref_model(input block_id_t lb, input logic [W-1:0] a);
    int n;
    longint total;
    n = 0;
    r_out = '0;
    for (int k = 0; k < NB; k++) begin
      if (m_id[k] == lb) begin
        if (n == 0) r_out = m_val[k];
        n++;
      end
    end
    r_hit   = (n > 0);
    r_multi = (n > 1);
    total   = longint'(r_out) + longint'(a);
    r_sum   = W'(total % (longint'(1) << W));
    r_carry = (total >= (longint'(1) << W));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [W-1:0] v0, input logic [W-1:0] v1,
                       input block_id_t i0, input block_id_t i1, input block_id_t lb,
                       input logic [W-1:0] a, input logic cap, input logic r);
    logic [W-1:0] exp_sq;
    @(negedge clk);
    dif.phi_in     = {v1, v0};
    dif.phi_s      = {i1, i0};
    dif.last_block = lb;
    dif.add_in1    = a;
    dif.capture    = cap;
    rst            = r;
    m_val[0] = v0; m_val[1] = v1;
    m_id[0]  = i0; m_id[1]  = i1;
    #1;
    ref_model(lb, a);
    check("phi_out", 64'(dif.phi_out), 64'(r_out));
    check("phi_hit", 64'(dif.phi_hit), 64'(r_hit));
    check("sum",     64'(dif.sum),     64'(r_sum));
    check("carry",   64'(dif.carry),   64'(r_carry));
`ifdef PHI_MULTI_MATCH_CHECK_EN
    check("phi_multi", 64'(dif.phi_multi), 64'(r_multi));
`endif
    if (r) model_sum_q = '0;
    else if (cap) model_sum_q = r_sum;
    exp_q.push_back(model_sum_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sum_q_queue_empty", 64'd1, 64'd0);
    end else begin
      exp_sq = exp_q.pop_front();
      check("sum_q", 64'(dif.sum_q), 64'(exp_sq));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    block_id_t i0;
    block_id_t i1;
    logic      r;
    dif.phi_in = '0; dif.phi_s = '0; dif.last_block = '0;
    dif.add_in1 = '0; dif.capture = 1'b0;

    // Reset with capture asserted and a nonzero sum: register must stay 0.
    cycle(20'h00000, 20'h00007, 0, 1, 1, 20'h3, 1'b1, 1'b1);
    cycle(20'h00000, 20'h00007, 0, 1, 1, 20'h3, 1'b1, 1'b1);
    check("reset_sum_q", 64'(dif.sum_q), 64'd0);

    // Low pair match, high pair match (captured), no match (captured).
    cycle(20'h00000, 20'h00005, 0, 1, 0, 20'h1, 1'b0, 1'b0);
    check("low_pair_sum", 64'(dif.sum), 64'd1);
    cycle(20'h00000, 20'h00005, 0, 1, 1, 20'h1, 1'b1, 1'b0);
    check("high_pair_sum_q", 64'(dif.sum_q), 64'd6);
    cycle(20'h00000, 20'h00005, 0, 1, 7, 20'h9, 1'b1, 1'b0);
    check("no_match_sum_q", 64'(dif.sum_q), 64'd9);
    cycle(20'h00000, 20'h00005, 0, 1, 7, 20'h4, 1'b0, 1'b0);
    check("hold_sum_q", 64'(dif.sum_q), 64'd9);

    // Wrap-around: 0xFFFFF + 1.
    cycle(20'hFFFFF, 20'h00005, 0, 1, 0, 20'h1, 1'b1, 1'b0);
    check("wrap_sum_q", 64'(dif.sum_q), 64'd0);

    // Load 42, then reset with capture still high.
    cycle(20'h00000, 20'h00005, 0, 1, 0, 20'd42, 1'b1, 1'b0);
    check("load_42", 64'(dif.sum_q), 64'd42);
    cycle(20'h00000, 20'h00005, 0, 1, 0, 20'd42, 1'b1, 1'b1);
    check("reset_over_capture", 64'(dif.sum_q), 64'd0);

    // Counter loop: sum_q fed back into pair 1, entered via block 0 once.
    cycle(20'h00000, dif.sum_q, 0, 1, 0, 20'h1, 1'b1, 1'b0);
    for (int n = 1; n < COUNT_N; n++) begin
      cycle(20'h00000, dif.sum_q, 0, 1, 1, 20'h1, 1'b1, 1'b0);
    end
    check("counter_final", 64'(dif.sum_q), 64'(COUNT_N));

    // Randomized traffic over a small ID space so matches and misses both occur.
    for (int t = 0; t < 400; t++) begin
      i0 = block_id_t'($urandom_range(0, 3));
      i1 = block_id_t'($urandom_range(0, 3));
      r  = ($urandom_range(0, 19) == 0);
`ifdef PHI_MULTI_MATCH_CHECK_EN
      if (!r && i1 == i0) i1 = i0 + 1;
`endif
      cycle(W'($urandom), W'($urandom), i0, i1, block_id_t'($urandom_range(0, 4)),
            W'($urandom), 1'($urandom_range(0, 1)), r);
    end

`ifdef PHI_MULTI_MATCH_CHECK_EN
    // Ambiguous match, kept under reset so the runtime check stays quiet.
    cycle(20'h00011, 20'h00022, 0, 0, 0, 20'h0, 1'b0, 1'b1);
    check("multi_flag", 64'(dif.phi_multi), 64'd1);
    check("multi_lowest", 64'(dif.phi_out), 64'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
